// File: rtl/bmm_pkg.sv
// bmm_pkg: shared types and constants for the bmm fixed-point datapath.
package bmm_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int BMM_WIDTH = 4;
    localparam int BMM_FRAC = 4;
    function automatic int max_signed(int w);
        return (1 << (w - 1)) - 1;
    endfunction
    function automatic int min_signed(int w);
        return -(1 << (w - 1));
    endfunction
endpackage

// File: rtl/div_fixed_step.sv
// div_fixed_step: one restoring shift-subtract step of the divider.
module div_fixed_step
    import bmm_pkg::*;
#(
    parameter int WIDTH = BMM_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             nbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             qbit
);
    logic [WIDTH+1:0] wide, dext;
    always_comb begin
        wide = {rem, nbit};
        dext = {2'b00, divisor};
        qbit = wide >= dext;
        rem_next = qbit ? (WIDTH+1)'(wide - dext) : (WIDTH+1)'(wide);
    end
endmodule

// File: rtl/div_fixed.sv
// div_fixed: sequential signed fixed-point divider, quotient = (dividend << FRAC) / divisor.
// Define DIV_FIXED_SATURATE_EN to saturate overflowing quotients; otherwise they wrap.
module div_fixed
    import bmm_pkg::*;
#(
    parameter int WIDTH = BMM_WIDTH,
    parameter int FRAC  = BMM_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int N = WIDTH + FRAC;
    localparam int CW = $clog2(N);
    localparam logic signed [N:0] q_max = (N+1)'(max_signed(WIDTH));
    localparam logic signed [N:0] q_min = (N+1)'(min_signed(WIDTH));
    localparam logic [WIDTH-1:0] w_max = WIDTH'(max_signed(WIDTH));
    localparam logic [WIDTH-1:0] w_min = WIDTH'(min_signed(WIDTH));

    state_t state, state_next;
    logic sign, qbit, ovf;
    logic [N-1:0] num, qfull;
    logic [N-2:0] qmag;
    logic [WIDTH-1:0] dvs, dividend_mag, divisor_mag, result;
    logic [WIDTH:0] rem, rem_next;
    logic [CW-1:0] cnt;
    logic signed [N:0] q;

    div_fixed_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem), .nbit(num[N-1]), .divisor(dvs), .rem_next(rem_next), .qbit(qbit)
    );

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_mag = divisor[WIDTH-1] ? -divisor : divisor;
        qfull = {qmag, qbit};
        q = sign ? -$signed({1'b0, qfull}) : $signed({1'b0, qfull});
        ovf = q > q_max || q < q_min;
`ifdef DIV_FIXED_SATURATE_EN
        result = ovf ? (sign ? w_min : w_max) : q[WIDTH-1:0];
`else
        result = q[WIDTH-1:0];
`endif
        state_next = state == IDLE ? (in_valid ? (divisor == '0 ? DONE : CALC) : IDLE)
                   : state == CALC ? (cnt == '0 ? DONE : CALC)
                   : (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_next;

    // The final step's quotient bit is folded straight into the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient <= '0;
            overflow <= 1'b0;
            div_by_zero <= 1'b0;
            sign <= 1'b0;
            num <= '0;
            dvs <= '0;
            rem <= '0;
            qmag <= '0;
            cnt <= '0;
        end else if (in_valid && in_ready) begin
            sign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            num <= {dividend_mag, {FRAC{1'b0}}};
            dvs <= divisor_mag;
            rem <= '0;
            qmag <= '0;
            cnt <= CW'(N - 1);
            overflow <= 1'b0;
            div_by_zero <= divisor == '0;
            if (divisor == '0) quotient <= dividend[WIDTH-1] ? w_min : w_max;
        end else if (state == CALC) begin
            rem <= rem_next;
            num <= num << 1;
            qmag <= qfull[N-2:0];
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                quotient <= result;
                overflow <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_div_fixed.sv
// tb_div_fixed: directed bench for div_fixed against an integer-arithmetic reference model.
module tb_div_fixed;
    localparam int W = 4;
    localparam int F = 4;
`ifdef DIV_FIXED_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, overflow, div_by_zero;
    logic [W-1:0] dividend = '0, divisor = '0, quotient;

    div_fixed #(.WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .overflow(overflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic ovf;
        logic dbz;
        int lat;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0, cap_lat = 0;
    bit seen = 1'b0;
    logic [W-1:0] cap_q = '0;
    logic cap_ovf = 1'b0, cap_dbz = 1'b0;

    task automatic chk(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // lat = edges after the accept edge until out_valid is seen (0: set by the accept edge)
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        int sa, sb, q;
        sa = $signed(a);
        sb = $signed(b);
        e.acc = 0;
        if (sb == 0) begin
            e.dbz = 1'b1;
            e.ovf = 1'b0;
            e.q = sa >= 0 ? 4'h7 : 4'h8;
            e.lat = 0;
        end else begin
            q = (sa * (1 << F)) / sb;
            e.dbz = 1'b0;
            e.ovf = q > 7 || q < -8;
            e.q = (e.ovf && SAT) ? (q > 0 ? 4'h7 : 4'h8) : q[W-1:0];
            e.lat = W + F;
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                chk("quotient", quotient, exp_q[0].q);
                chk("overflow", overflow, exp_q[0].ovf);
                chk("div_by_zero", div_by_zero, exp_q[0].dbz);
                if (!seen) begin
                    cap_lat = cyc - exp_q[0].acc;
                    chk("latency", cap_lat, exp_q[0].lat);
                    cap_q = quotient;
                    cap_ovf = overflow;
                    cap_dbz = div_by_zero;
                    seen = 1'b1;
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run(logic [W-1:0] a, logic [W-1:0] b, int hold,
                       logic [W-1:0] lq_sat, logic [W-1:0] lq_wrap, logic lovf, logic ldbz);
        exp_t e;
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        out_ready = hold == 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = model(a, b);
        e.acc = cyc;
        seen = 1'b0;
        exp_q.push_back(e);
        if (!ldbz) chk("busy_in_ready", in_ready, 0);
        for (int k = 0; k < 20 && !seen; k++) @(negedge clk);
        if (!seen) chk("timeout", 0, 1);
        @(posedge clk);
        #1;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                chk("bp_in_ready", in_ready, 0);
                dividend = ~a;
                divisor = 4'h1;
                in_valid = 1'b1;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("release_out_valid", out_valid, 0);
        end
        chk("idle_in_ready", in_ready, 1);
        chk("lit_quotient", cap_q, SAT ? lq_sat : lq_wrap);
        chk("lit_overflow", cap_ovf, lovf);
        chk("lit_div_by_zero", cap_dbz, ldbz);
        chk("lit_latency", cap_lat, ldbz ? 0 : W + F);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        //   a      b      hold sat    wrap   ovf   dbz
        run(4'h1, 4'h4, 0, 4'h4, 4'h4, 1'b0, 1'b0);
        run(4'hF, 4'h3, 0, 4'hB, 4'hB, 1'b0, 1'b0);
        run(4'h2, 4'h4, 0, 4'h7, 4'h8, 1'b1, 1'b0);
        run(4'h8, 4'h8, 0, 4'h7, 4'h0, 1'b1, 1'b0);
        run(4'h3, 4'h0, 0, 4'h7, 4'h7, 1'b0, 1'b1);
        run(4'h9, 4'h0, 0, 4'h8, 4'h8, 1'b0, 1'b1);
        run(4'h1, 4'h8, 0, 4'hE, 4'hE, 1'b0, 1'b0);
        run(4'hF, 4'h2, 0, 4'h8, 4'h8, 1'b0, 1'b0);
        run(4'hC, 4'h7, 0, 4'h8, 4'h7, 1'b1, 1'b0);
        run(4'h6, 4'hD, 0, 4'h8, 4'h0, 1'b1, 1'b0);
        run(4'h0, 4'h5, 0, 4'h0, 4'h0, 1'b0, 1'b0);
        run(4'hF, 4'hF, 0, 4'h7, 4'h0, 1'b1, 1'b0);
        run(4'h3, 4'h7, 5, 4'h6, 4'h6, 1'b0, 1'b0);
        run(4'h8, 4'h0, 3, 4'h8, 4'h8, 1'b0, 1'b1);
        // Reset mid-CALC: the in-flight operation must vanish without a result.
        dividend = 4'h1;
        divisor = 4'h4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_div_by_zero", div_by_zero, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("stale_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        run(4'h1, 4'h7, 0, 4'h2, 4'h2, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
